fft_bitrev_buffer: RTL

FFT_BITREV_BUFFER -- requirements
Module: fft_bitrev_buffer

---
 rtl/fft_bitrev_buffer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fft_bitrev_buffer.sv
// rtl/fft_bitrev_buffer.sv - ping-pong frame buffer with natural or bit-reversed read order
module fft_bitrev_buffer #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_push,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              in_stall,
    input  logic              bitrev_en,
    output logic              out_push,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic              out_first,
    output logic              out_last,
    input  logic              out_stall
);

    localparam int N = 1 << LOG2N;
    localparam int W = 2 * DATA_W;
    localparam logic [LOG2N-1:0] CNT_ONE = {{(LOG2N-1){1'b0}}, 1'b1};

    // Sample storage: [bank][address], real in the upper half, imag in the lower half.
    logic [W-1:0]     mem_q [2][N];

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             mode_q, mode_d;
    logic             out_push_q, out_push_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;
    logic [W-1:0]     out_data_q, out_data_d;

    logic             wr_fire;
    logic             wr_last;
    logic             out_fire;
    logic             load;
    logic             rd_first;
    logic             rd_last;
    logic             mode_eff;
    logic [LOG2N-1:0] rd_rev;
    logic [LOG2N-1:0] rd_addr;
    logic [W-1:0]     rd_word;

    // Handshake qualifiers; stall comes only from the registered full flag.
    always_comb begin
        in_stall = full_q[wr_bank_q];
        wr_fire  = in_push & ~full_q[wr_bank_q];
        wr_last  = &wr_cnt_q;
        out_fire = out_push_q & ~out_stall;
        load     = full_q[rd_bank_q] & (~out_push_q | out_fire);
        rd_first = (rd_cnt_q == '0);
        rd_last  = &rd_cnt_q;
    end

    // Read address: the mode for sample 0 is taken live because it is latched on that same load.
    always_comb begin
        rd_rev = '0;
        for (int i = 0; i < LOG2N; i++) begin
            rd_rev[i] = rd_cnt_q[LOG2N-1-i];
        end
        mode_eff = rd_first ? bitrev_en : mode_q;
        rd_addr  = mode_eff ? rd_rev : rd_cnt_q;
        rd_word  = mem_q[rd_bank_q][rd_addr];
    end

    // Next-state for write side, read side and output register.
    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        mode_d      = mode_q;
        out_push_d  = out_push_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (wr_fire) begin
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_ONE;
            end
        end

        if (out_fire) begin
            out_push_d = 1'b0;
        end

        // A load overrides the drain above so a transfer and refill share one edge.
        if (load) begin
            out_push_d  = 1'b1;
            out_data_d  = rd_word;
            out_first_d = rd_first;
            out_last_d  = rd_last;
            if (rd_first) begin
                mode_d = bitrev_en;
            end
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                rd_cnt_d          = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + CNT_ONE;
            end
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            mode_q      <= 1'b0;
            out_push_q  <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            mode_q      <= mode_d;
            out_push_q  <= out_push_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Sample memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_cnt_q] <= {in_real, in_imag};
        end
    end

    assign out_push  = out_push_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_real  = out_data_q[W-1:DATA_W];
    assign out_imag  = out_data_q[DATA_W-1:0];

endmodule
